// File: rtl/datamem_arb_pkg.sv
// Shared types and widths for the two-port data-memory arbiter.
// Build option DATAMEM_ARB_RANGE_CHECK_EN enables the addr_bad() range check in the top.
package datamem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  // Word index beyond the memory, or a non word-aligned byte address
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[ADDR_W-1:2] >= (ADDR_W-2)'(depth)) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// One requester port of the data-memory arbiter: request payload in, grant/read return out.
interface datamem_arbiter_if;
  import datamem_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/datamem_arb_starve_ctr.sv
// Counts consecutive cycles port 1 is denied; flags starvation once MAX_WAIT is reached.
module datamem_arb_starve_ctr
  import datamem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p1_req_i,
  input  logic p1_gnt_i,
  output logic starved_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              starved_q, starved_d;

  // Saturating denial count; any grant or dropped request restarts it
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req_i || p1_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    starved_d = (wait_cnt_d == MAX_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
    end
  end

  assign starved_o = starved_q;

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (registered read, one access/cycle).
// Build option DATAMEM_ARB_RANGE_CHECK_EN adds err_o and suppresses out-of-range accesses.
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  datamem_arbiter_if.slave  p0,
  datamem_arbiter_if.slave  p1,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              p1_starved_o
`ifdef DATAMEM_ARB_RANGE_CHECK_EN
  ,
  output logic              err_o
`endif
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || DEPTH == 0) begin : g_param_check
    $error("datamem_arbiter: MAX_WAIT must be 1..15 and DEPTH nonzero");
  end

  logic              p0_gnt_c, p1_gnt_c, any_gnt_c;
  logic              win_we_c, acc_ok_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic [DATA_W-1:0] rdata_c;
  owner_t            owner_q, owner_d;

  datamem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .p1_req_i  (p1.req),
    .p1_gnt_i  (p1_gnt_c),
    .starved_o (p1_starved_o)
  );

  // Port 0 has priority unless port 1 has been starved; nothing is granted in reset
  always_comb begin
    p1_gnt_c  = rst_n & p1.req & (~p0.req | p1_starved_o);
    p0_gnt_c  = rst_n & p0.req & ~p1_gnt_c;
    any_gnt_c = p0_gnt_c | p1_gnt_c;
  end

  always_comb begin
    win_we_c    = 1'b0;
    win_addr_c  = '0;
    win_wdata_c = '0;
    if (p1_gnt_c) begin
      win_we_c    = p1.we;
      win_addr_c  = p1.addr;
      win_wdata_c = p1.wdata;
    end else if (p0_gnt_c) begin
      win_we_c    = p0.we;
      win_addr_c  = p0.addr;
      win_wdata_c = p0.wdata;
    end
  end

`ifdef DATAMEM_ARB_RANGE_CHECK_EN
  assign acc_ok_c = ~addr_bad(win_addr_c, DEPTH);
`else
  assign acc_ok_c = 1'b1;
`endif

  assign mem_addr_o  = win_addr_c;
  assign mem_wdata_o = win_wdata_c;
  assign mem_read_o  = any_gnt_c & ~win_we_c & acc_ok_c;
  assign mem_write_o = any_gnt_c &  win_we_c & acc_ok_c;

  // Owner of the data returning next cycle: only granted reads claim it
  always_comb begin
    owner_d = OWN_NONE;
    if (p1_gnt_c && !p1.we) begin
      owner_d = OWN_P1;
    end else if (p0_gnt_c && !p0.we) begin
      owner_d = OWN_P0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

`ifdef DATAMEM_ARB_RANGE_CHECK_EN
  logic rd_bad_q, err_q;

  // A rejected read still completes, but returns zero instead of memory data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bad_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_bad_q <= (owner_d != OWN_NONE) & ~acc_ok_c;
      err_q    <= any_gnt_c & ~acc_ok_c;
    end
  end

  assign err_o   = err_q;
  assign rdata_c = (owner_q != OWN_NONE && !rd_bad_q) ? mem_rdata_i : '0;
`else
  assign rdata_c = (owner_q != OWN_NONE) ? mem_rdata_i : '0;
`endif

  assign p0.gnt    = p0_gnt_c;
  assign p1.gnt    = p1_gnt_c;
  assign p0.rvalid = (owner_q == OWN_P0);
  assign p1.rvalid = (owner_q == OWN_P1);
  assign p0.rdata  = rdata_c;
  assign p1.rdata  = rdata_c;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: memory model, directed scenarios, randomized traffic vs a reference model.
module tb_datamem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, p1_starved;
`ifdef DATAMEM_ARB_RANGE_CHECK_EN
  logic        err;
`endif

  int n_vec = 0;
  int n_err = 0;

  datamem_arbiter_if p0_if ();
  datamem_arbiter_if p1_if ();

  datamem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0           (p0_if),
    .p1           (p1_if),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_rdata_i  (mem_rdata),
    .p1_starved_o (p1_starved)
`ifdef DATAMEM_ARB_RANGE_CHECK_EN
    ,
    .err_o        (err)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: 256 words, registered read, index wraps on addr[9:2]
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, predicted for the coming edge at every falling edge
  logic [31:0] ref_mem [256];
  int          m_wait = 0;
  logic        pend0 = 1'b0, pend1 = 1'b0, pend_err = 1'b0;
  logic [31:0] pend_data = '0;

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef DATAMEM_ARB_RANGE_CHECK_EN
    logic [29:0] widx;
    widx = a[31:2];
    return (widx >= 30'(DEPTH)) || (a[1:0] != 2'b00);
`else
    return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  always @(negedge clk) begin : compare
    logic        p0w, p1w, wwe, wbad;
    logic [31:0] waddr, wdat;
    if (!rst_n) begin
      chk1("rst_p0_gnt", p0_if.gnt, 1'b0);
      chk1("rst_p1_gnt", p1_if.gnt, 1'b0);
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_p0_rvalid", p0_if.rvalid, 1'b0);
      chk1("rst_p1_rvalid", p1_if.rvalid, 1'b0);
      chk32("rst_rdata", p0_if.rdata, 32'h0);
      chk1("rst_starved", p1_starved, 1'b0);
      m_wait = 0; pend0 = 1'b0; pend1 = 1'b0; pend_err = 1'b0; pend_data = '0;
    end else begin
      p1w = p1_if.req && (!p0_if.req || m_wait == MAX_WAIT);
      p0w = p0_if.req && !p1w;
      wwe = p1w ? p1_if.we : (p0w ? p0_if.we : 1'b0);
      waddr = p1w ? p1_if.addr : (p0w ? p0_if.addr : 32'h0);
      wdat  = p1w ? p1_if.wdata : (p0w ? p0_if.wdata : 32'h0);
      wbad = (p0w || p1w) && bad_addr(waddr);
      chk1("p0_gnt", p0_if.gnt, p0w);
      chk1("p1_gnt", p1_if.gnt, p1w);
      chk1("mem_read", mem_read, (p0w || p1w) && !wwe && !wbad);
      chk1("mem_write", mem_write, (p0w || p1w) && wwe && !wbad);
      chk32("mem_addr", mem_addr, waddr);
      chk32("mem_wdata", mem_wdata, wdat);
      chk1("p0_rvalid", p0_if.rvalid, pend0);
      chk1("p1_rvalid", p1_if.rvalid, pend1);
      chk32("p0_rdata", p0_if.rdata, (pend0 || pend1) ? pend_data : 32'h0);
      chk32("p1_rdata", p1_if.rdata, (pend0 || pend1) ? pend_data : 32'h0);
      chk1("p1_starved", p1_starved, m_wait == MAX_WAIT);
`ifdef DATAMEM_ARB_RANGE_CHECK_EN
      chk1("err", err, pend_err);
`endif
      pend0     = p0w && !p0_if.we;
      pend1     = p1w && !p1_if.we;
      pend_data = wbad ? 32'h0 : ref_mem[waddr[9:2]];
      pend_err  = wbad;
      if ((p0w || p1w) && wwe && !wbad) ref_mem[waddr[9:2]] = wdat;
      if (p1_if.req && !p1w) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      else                   m_wait = 0;
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #2;
    p0_if.req = r0; p0_if.we = w0; p0_if.addr = a0; p0_if.wdata = d0;
    p1_if.req = r1; p1_if.we = w1; p1_if.addr = a1; p1_if.wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    // Reset with both ports requesting: nothing may be granted
    rst_n = 1'b0;
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 32'h10; p0_if.wdata = 32'h0;
    p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 32'h20; p1_if.wdata = 32'h5;
    #3;
    chk1("lit_rst_p0_gnt", p0_if.gnt, 1'b0);
    chk1("lit_rst_p1_gnt", p1_if.gnt, 1'b0);
    chk1("lit_rst_mem_write", mem_write, 1'b0);
    chk32("lit_rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle();
    idle();

    // Write then read of the same word on consecutive cycles
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0); #2;
    chk1("lit_wr_gnt", p0_if.gnt, 1'b1);
    chk1("lit_wr_mem_write", mem_write, 1'b1);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #2;
    chk1("lit_rd_gnt", p0_if.gnt, 1'b1);
    chk1("lit_rd_mem_read", mem_read, 1'b1);
    idle(); #2;
    chk1("lit_rd_rvalid", p0_if.rvalid, 1'b1);
    chk32("lit_rd_rdata", p0_if.rdata, 32'hDEADBEEF);
    idle(); #2;
    chk1("lit_rd_rvalid_once", p0_if.rvalid, 1'b0);

    // Starvation: p0 reads every cycle, p1 read waits MAX_WAIT cycles
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D); #2;
    chk1("lit_p1_wr_gnt", p1_if.gnt, 1'b1);
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0); #2;
      chk1("lit_starve_p1_denied", p1_if.gnt, 1'b0);
      chk1("lit_starve_p0_gnt", p0_if.gnt, 1'b1);
      chk1("lit_starve_flag_low", p1_starved, 1'b0);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0); #2;
    chk1("lit_starve_flag", p1_starved, 1'b1);
    chk1("lit_starve_p1_gnt", p1_if.gnt, 1'b1);
    chk1("lit_starve_p0_held", p0_if.gnt, 1'b0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #2;
    chk1("lit_starve_p1_rvalid", p1_if.rvalid, 1'b1);
    chk32("lit_starve_p1_rdata", p1_if.rdata, 32'hCAFEF00D);
    chk1("lit_starve_p0_regrant", p0_if.gnt, 1'b1);
    chk1("lit_starve_flag_clr", p1_starved, 1'b0);
    idle(); #2;
    chk32("lit_starve_p0_rdata", p0_if.rdata, 32'hDEADBEEF);

    // Alternating back-to-back reads
    drive(1'b1, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h4, 32'h22222222, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h8, 32'h33333333, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #2;
    chk1("lit_alt_gnt0", p0_if.gnt, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0); #2;
    chk1("lit_alt_gnt1", p1_if.gnt, 1'b1);
    chk1("lit_alt_rv0_a", p0_if.rvalid, 1'b1);
    chk32("lit_alt_rdata_a", p0_if.rdata, 32'h11111111);
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #2;
    chk1("lit_alt_rv1", p1_if.rvalid, 1'b1);
    chk1("lit_alt_rv0_gap", p0_if.rvalid, 1'b0);
    chk32("lit_alt_rdata_b", p1_if.rdata, 32'h22222222);
    idle(); #2;
    chk1("lit_alt_rv0_b", p0_if.rvalid, 1'b1);
    chk32("lit_alt_rdata_c", p0_if.rdata, 32'h33333333);

    // Reset right after a p1 read grant drops the in-flight read
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0); #2;
    chk1("lit_rst_inflight_gnt", p1_if.gnt, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    p1_if.req = 1'b0;
    #1;
    chk1("lit_rst_inflight_rv", p1_if.rvalid, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(); #2;
    chk1("lit_rst_release_rv1", p1_if.rvalid, 1'b0);
    chk32("lit_rst_release_rdata", p1_if.rdata, 32'h0);

`ifdef DATAMEM_ARB_RANGE_CHECK_EN
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0); #2;
    chk1("lit_rc_gnt", p1_if.gnt, 1'b1);
    chk1("lit_rc_mem_read", mem_read, 1'b0);
    idle(); #2;
    chk1("lit_rc_err", err, 1'b1);
    chk1("lit_rc_rvalid", p1_if.rvalid, 1'b1);
    chk32("lit_rc_rdata", p1_if.rdata, 32'h0);
`endif

    // Randomized traffic checked by the reference model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a0, a1;
      a0 = 32'($urandom_range(0, 15)) << 2;
      a1 = 32'($urandom_range(0, 15)) << 2;
`ifdef DATAMEM_ARB_RANGE_CHECK_EN
      if ($urandom_range(0, 15) == 0) a0 = 32'h400 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a1 = a1 + 32'h1;
`endif
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a0, $urandom,
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0), a1, $urandom);
      rst_n = 1'($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1;
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
